// File: rtl/sub_pp2_hs.sv
// Two-stage pipelined subtractor A-B, split at half width; optional clamp via SUB_PP2_SAT_EN.
// Latency 2 cycles, 1 result/cycle; valid/ready with combinational O_ready that opens when the pipe can advance.
module sub_pp2_hs #(
    parameter int C_IN1 = 12,
    parameter int C_IN2 = 12,
    parameter int C_OUT = 13
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_valid,
    output logic               O_ready,
    input  logic [C_IN1-1:0]   I_a,
    input  logic [C_IN2-1:0]   I_b,
    output logic               O_valid,
    input  logic               I_ready,
    output logic [C_OUT-1:0]   O_dout,
    output logic               O_borrow,
    output logic [15:0]        O_cnt
);

    localparam int C_MAX = (C_IN1 > C_IN2) ? C_IN1 : C_IN2;
    localparam int C_IN  = C_MAX + (C_MAX % 2);
    localparam int H     = C_IN / 2;
    localparam int DW    = C_IN + 1;
    localparam int XW    = (C_OUT > DW) ? C_OUT : DW;

    logic [C_IN-1:0]        a_x, b_x;
    logic [H:0]             lo_d, hi_d;
    logic signed [DW-1:0]   d_s;
    logic signed [XW-1:0]   d_x;
    logic [C_OUT-1:0]       out_d;
    logic                   en1, en2;

    logic                   v1_q, bor1_q;
    logic [H-1:0]           lo_q, ahi_q, bhi_q;
    logic                   v2_q, borrow_q;
    logic [C_OUT-1:0]       dout_q;
    logic [15:0]            cnt_q;

    assign a_x = C_IN'(I_a);
    assign b_x = C_IN'(I_b);

    assign en2     = !v2_q || I_ready;
    assign en1     = !v1_q || en2;
    assign O_ready = en1;

    assign lo_d = {1'b0, a_x[H-1:0]} - {1'b0, b_x[H-1:0]};
    // The low-half borrow is folded into the upper difference so D needs no extra carry stage.
    assign hi_d = {1'b0, ahi_q} - {1'b0, bhi_q} - {{H{1'b0}}, bor1_q};
    assign d_s  = {hi_d, lo_q};
    assign d_x  = XW'(d_s);

    always_comb begin
        out_d = d_x[C_OUT-1:0];
`ifdef SUB_PP2_SAT_EN
        // Overflow when the bits above the output sign are not a pure sign extension.
        if (!(&d_x[XW-1:C_OUT-1]) && (|d_x[XW-1:C_OUT-1])) begin
            out_d = d_x[XW-1] ? {1'b1, {(C_OUT-1){1'b0}}} : {1'b0, {(C_OUT-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            v1_q     <= 1'b0;
            bor1_q   <= 1'b0;
            lo_q     <= '0;
            ahi_q    <= '0;
            bhi_q    <= '0;
            v2_q     <= 1'b0;
            borrow_q <= 1'b0;
            dout_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (en1) begin
                v1_q <= I_valid;
                if (I_valid) begin
                    lo_q   <= lo_d[H-1:0];
                    bor1_q <= lo_d[H];
                    ahi_q  <= a_x[C_IN-1:H];
                    bhi_q  <= b_x[C_IN-1:H];
                end
            end
            if (en2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    dout_q   <= out_d;
                    borrow_q <= d_s[DW-1];
                end
            end
            if (v2_q && I_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign O_valid  = v2_q;
    assign O_dout   = dout_q;
    assign O_borrow = borrow_q;
    assign O_cnt    = cnt_q;

endmodule

// File: tb/tb_sub_pp2_hs.sv
// Directed bench for sub_pp2_hs: default, cross-half (H=7) and narrow-output (C_OUT=8) instances.
module tb_sub_pp2_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    // default instance
    logic        m_vi, m_ro, m_vo, m_ri, m_bor;
    logic [11:0] m_a, m_b;
    logic [12:0] m_dout;
    logic [15:0] m_cnt;

    // C_IN1=11, C_IN2=13 -> H=7, result 15 bits
    logic        h_vi, h_ro, h_vo, h_ri, h_bor;
    logic [10:0] h_a;
    logic [12:0] h_b;
    logic [14:0] h_dout;
    logic [15:0] h_cnt;

    // C_OUT=8
    logic        n_vi, n_ro, n_vo, n_ri, n_bor;
    logic [11:0] n_a, n_b;
    logic [7:0]  n_dout;
    logic [15:0] n_cnt;

    sub_pp2_hs u_main (
        .I_clk(clk), .I_rst(rst), .I_valid(m_vi), .O_ready(m_ro), .I_a(m_a), .I_b(m_b),
        .O_valid(m_vo), .I_ready(m_ri), .O_dout(m_dout), .O_borrow(m_bor), .O_cnt(m_cnt)
    );

    sub_pp2_hs #(.C_IN1(11), .C_IN2(13), .C_OUT(15)) u_h7 (
        .I_clk(clk), .I_rst(rst), .I_valid(h_vi), .O_ready(h_ro), .I_a(h_a), .I_b(h_b),
        .O_valid(h_vo), .I_ready(h_ri), .O_dout(h_dout), .O_borrow(h_bor), .O_cnt(h_cnt)
    );

    sub_pp2_hs #(.C_OUT(8)) u_c8 (
        .I_clk(clk), .I_rst(rst), .I_valid(n_vi), .O_ready(n_ro), .I_a(n_a), .I_b(n_b),
        .O_valid(n_vo), .I_ready(n_ri), .O_dout(n_dout), .O_borrow(n_bor), .O_cnt(n_cnt)
    );

    task automatic test_reset();
        rst = 1'b1;
        m_vi = 1'b0; m_ri = 1'b1; m_a = '0; m_b = '0;
        h_vi = 1'b0; h_ri = 1'b1; h_a = '0; h_b = '0;
        n_vi = 1'b0; n_ri = 1'b1; n_a = '0; n_b = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_ro !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", m_ro); end
        checks++;
        if (m_vo !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_vo); end
        checks++;
        if (m_cnt !== 16'd0 || m_dout !== 13'd0 || m_bor !== 1'b0) begin
            errors++; $display("FAIL reset_state: cnt=%0d dout=%0h bor=%b expected 0/0/0", m_cnt, m_dout, m_bor);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_ro !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b expected 1", m_ro); end
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        m_a = 12'd100; m_b = 12'd30; m_vi = 1'b1; m_ri = 1'b1;
        checks++;
        if (m_ro !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", m_ro); end
        @(negedge clk);
        m_vi = 1'b0;
        checks++;
        if (m_vo !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0 at cycle 1", m_vo); end
        @(negedge clk);
        checks++;
        if (m_vo !== 1'b1 || m_dout !== 13'd70 || m_bor !== 1'b0) begin
            errors++; $display("FAIL basic_result: valid=%b dout=%0d bor=%b expected 1/70/0", m_vo, m_dout, m_bor);
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 1;
        checks++;
        if (m_cnt !== 16'(exp_cnt) || m_vo !== 1'b0) begin
            errors++; $display("FAIL basic_cnt: cnt=%0d valid=%b expected %0d/0", m_cnt, m_vo, exp_cnt);
        end
    endtask

    task automatic test_negative();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        m_a = 12'd0; m_b = 12'd1; m_vi = 1'b1; m_ri = 1'b1;
        @(negedge clk);
        m_vi = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (m_vo) begin
                seen = 1'b1;
                checks++;
                if (m_dout !== 13'h1FFF || m_bor !== 1'b1) begin
                    errors++; $display("FAIL neg_result: dout=%0h bor=%b expected 1fff/1", m_dout, m_bor);
                end
            end
            @(negedge clk);
        end
        if (!seen) begin errors++; checks++; $display("FAIL neg_timeout: no valid within 5 cycles, expected one"); end
        exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_back_to_back();
        int exp_q[3];
        int k;
        bit hold_ok;
        exp_q = '{4, 7, 0};
        k = 0;
        hold_ok = 1'b1;
        @(negedge clk);
        m_ri = 1'b0; m_vi = 1'b1; m_a = 12'd5; m_b = 12'd1;
        checks++;
        if (m_ro !== 1'b1) begin errors++; $display("FAIL b2b_accept1: ready=%b expected 1", m_ro); end
        @(negedge clk);
        m_a = 12'd9; m_b = 12'd2;
        checks++;
        if (m_ro !== 1'b1) begin errors++; $display("FAIL b2b_accept2: ready=%b expected 1", m_ro); end
        @(negedge clk);
        m_a = 12'd7; m_b = 12'd7;
        checks++;
        if (m_ro !== 1'b0 || m_vo !== 1'b1 || m_dout !== 13'd4) begin
            errors++; $display("FAIL b2b_full: ready=%b valid=%b dout=%0d expected 0/1/4", m_ro, m_vo, m_dout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_ro !== 1'b0 || m_vo !== 1'b1 || m_dout !== 13'd4 || m_bor !== 1'b0) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            errors++; $display("FAIL b2b_hold: ready=%b valid=%b dout=%0d expected 0/1/4 held", m_ro, m_vo, m_dout);
        end
        m_ri = 1'b1;
        #1;
        checks++;
        if (m_ro !== 1'b1) begin errors++; $display("FAIL b2b_full_accept: ready=%b expected 1", m_ro); end
        for (int i = 0; i < 6; i++) begin
            if (i == 1) m_vi = 1'b0;
            if (m_vo) begin
                checks++;
                if (k >= 3) begin
                    errors++; $display("FAIL b2b_extra: got %0d expected no further result", m_dout);
                end else if (m_dout !== 13'(exp_q[k])) begin
                    errors++; $display("FAIL b2b_order: result %0d got %0d expected %0d", k, m_dout, exp_q[k]);
                end
                k++;
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 3;
        checks++;
        if (k != 3 || m_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL b2b_count: results=%0d cnt=%0d expected 3/%0d", k, m_cnt, exp_cnt);
        end
    endtask

    task automatic test_cross_half();
        @(negedge clk);
        h_a = 11'd128; h_b = 13'd1; h_vi = 1'b1;
        @(negedge clk);
        h_a = 11'd128; h_b = 13'd129;
        @(negedge clk);
        h_vi = 1'b0;
        checks++;
        if (h_vo !== 1'b1 || h_dout !== 15'd127 || h_bor !== 1'b0) begin
            errors++; $display("FAIL cross_128m1: valid=%b dout=%0h bor=%b expected 1/7f/0", h_vo, h_dout, h_bor);
        end
        @(negedge clk);
        checks++;
        if (h_vo !== 1'b1 || h_dout !== 15'h7FFF || h_bor !== 1'b1) begin
            errors++; $display("FAIL cross_128m129: valid=%b dout=%0h bor=%b expected 1/7fff/1", h_vo, h_dout, h_bor);
        end
    endtask

    task automatic test_narrow();
        logic [7:0] exp_pos, exp_neg;
`ifdef SUB_PP2_SAT_EN
        exp_pos = 8'h7F; exp_neg = 8'h80;
`else
        exp_pos = 8'hFF; exp_neg = 8'h01;
`endif
        @(negedge clk);
        n_a = 12'd4095; n_b = 12'd0; n_vi = 1'b1;
        @(negedge clk);
        n_a = 12'd0; n_b = 12'd4095;
        @(negedge clk);
        n_vi = 1'b0;
        checks++;
        if (n_vo !== 1'b1 || n_dout !== exp_pos || n_bor !== 1'b0) begin
            errors++; $display("FAIL narrow_pos: valid=%b dout=%0h bor=%b expected 1/%0h/0", n_vo, n_dout, n_bor, exp_pos);
        end
        @(negedge clk);
        checks++;
        if (n_vo !== 1'b1 || n_dout !== exp_neg || n_bor !== 1'b1) begin
            errors++; $display("FAIL narrow_neg: valid=%b dout=%0h bor=%b expected 1/%0h/1", n_vo, n_dout, n_bor, exp_neg);
        end
    endtask

    task automatic test_reset_flush();
        bit stale;
        stale = 1'b0;
        @(negedge clk);
        m_ri = 1'b0; m_vi = 1'b1; m_a = 12'd3; m_b = 12'd1;
        @(negedge clk);
        m_a = 12'd6; m_b = 12'd1;
        @(negedge clk);
        m_vi = 1'b0;
        checks++;
        if (m_vo !== 1'b1 || m_ro !== 1'b0) begin
            errors++; $display("FAIL flush_full: valid=%b ready=%b expected 1/0", m_vo, m_ro);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_vo !== 1'b0 || m_cnt !== 16'd0 || m_ro !== 1'b1) begin
            errors++; $display("FAIL flush_async: valid=%b cnt=%0d ready=%b expected 0/0/1", m_vo, m_cnt, m_ro);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ri = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_vo !== 1'b0 || m_cnt !== 16'd0) stale = 1'b1;
        end
        checks++;
        if (stale) begin errors++; $display("FAIL flush_stale: valid=%b cnt=%0d expected 0/0", m_vo, m_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_cross_half();
        test_narrow();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
